// File: rtl/alu.sv
// Registered 8-bit ALU: ADD/SUB/INV/ORR on unsigned operands.
// Result and carry/zero flags appear one clock after the operands are sampled.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [1:0] opcode,
  output logic [7:0] Y,
  output logic       carry,
  output logic       zero
);

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    INV = 2'b10,
    ORR = 2'b11
  } op_code_e;

  op_code_e   op;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] y_next;
  logic       carry_next;
  logic       zero_next;

  assign op   = op_code_e'(opcode);
  assign sum  = {1'b0, A} + {1'b0, B};
  // Bit 8 of the zero-extended difference is the borrow (set when A < B).
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    y_next     = sum[7:0];
    carry_next = sum[8];
    case (op)
      ADD: begin
        y_next     = sum[7:0];
        carry_next = sum[8];
      end
      SUB: begin
        y_next     = diff[7:0];
        carry_next = diff[8];
      end
      INV: begin
        y_next     = ~A;
        carry_next = 1'b0;
      end
      ORR: begin
        y_next     = A | B;
        carry_next = 1'b0;
      end
      default: begin
        y_next     = sum[7:0];
        carry_next = sum[8];
      end
    endcase
  end

  assign zero_next = (y_next == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y     <= 8'h00;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else begin
      Y     <= y_next;
      carry <= carry_next;
      zero  <= zero_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences,
// and randomized operations compared against an arithmetic reference model.
module tb_alu;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] opcode;
  logic [7:0] Y;
  logic       carry;
  logic       zero;

  int n_total;
  int n_pass;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] y;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .Y      (Y),
    .carry  (carry),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference computed from the operation rules with plain integer arithmetic.
  task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           output logic [7:0] y, output logic c, output logic z);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    case (op)
      OP_SUB: begin
        r = (ia - ib + 256) % 256;
        c = (ia < ib);
      end
      OP_INV: r = 255 - ia;
      OP_ORR: r = int'(a | b);
      default: begin
        r = (ia + ib) % 256;
        c = ((ia + ib) > 255);
      end
    endcase
    y = r[7:0];
    z = (r == 0);
  endtask

  task automatic check_out(input string name, input logic [7:0] ey, input logic ec, input logic ez);
    n_total++;
    if (Y === ey && carry === ec && zero === ez)
      n_pass++;
    else
      $display("FAIL %s: got Y=%h carry=%b zero=%b, expected Y=%h carry=%b zero=%b",
               name, Y, carry, zero, ey, ec, ez);
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge clk);
    A      = a;
    B      = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] y, input logic c, input logic z);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.y = y; v.c = c; v.z = z;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] ey;
    logic       ec, ez;
    n_total = 0;
    n_pass  = 0;

    add_vec("sweep_add",   8'h0F, 8'hF0, OP_ADD, 8'hFF, 1'b0, 1'b0);
    add_vec("sweep_sub",   8'h0F, 8'hF0, OP_SUB, 8'h1F, 1'b1, 1'b0);
    add_vec("sweep_inv",   8'h0F, 8'hF0, OP_INV, 8'hF0, 1'b0, 1'b0);
    add_vec("sweep_orr",   8'h0F, 8'hF0, OP_ORR, 8'hFF, 1'b0, 1'b0);
    add_vec("add_ff_01",   8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1);
    add_vec("add_80_80",   8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1);
    add_vec("sub_00_01",   8'h00, 8'h01, OP_SUB, 8'hFF, 1'b1, 1'b0);
    add_vec("sub_55_55",   8'h55, 8'h55, OP_SUB, 8'h00, 1'b0, 1'b1);
    add_vec("sub_f0_0f",   8'hF0, 8'h0F, OP_SUB, 8'hE1, 1'b0, 1'b0);
    add_vec("inv_ff",      8'hFF, 8'h12, OP_INV, 8'h00, 1'b0, 1'b1);
    add_vec("orr_00_00",   8'h00, 8'h00, OP_ORR, 8'h00, 1'b0, 1'b1);
    add_vec("orr_a5_5a",   8'hA5, 8'h5A, OP_ORR, 8'hFF, 1'b0, 1'b0);
    add_vec("add_12_34",   8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0);

    // Reset held with clocks running.
    rst_n  = 1'b0;
    A      = 8'h0F;
    B      = 8'hF0;
    opcode = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_hold", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back-to-back on successive cycles.
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      check_out(vecs[i].name, vecs[i].y, vecs[i].c, vecs[i].z);
    end

    // Asynchronous reset mid-cycle clears outputs before any edge.
    apply(8'h0F, 8'hF0, OP_ADD);
    check_out("pre_async_reset", 8'hFF, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hF0, 8'h0F, OP_SUB);
    check_out("after_reset_release", 8'hE1, 1'b0, 1'b0);

    // Inputs changed between edges must not disturb outputs.
    apply(8'h00, 8'h01, OP_SUB);
    #1;
    A      = 8'h55;
    B      = 8'h55;
    opcode = OP_ORR;
    @(negedge clk);
    check_out("hold_between_edges", 8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_out("hold_next_edge", 8'h55, 1'b0, 1'b0);

    // Randomized stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rop;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 2'($urandom_range(0, 3));
      ref_model(ra, rb, rop, ey, ec, ez);
      apply(ra, rb, rop);
      check_out($sformatf("rand_%0d", i), ey, ec, ez);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 8-bit arithmetic/logic unit with a 2-bit operation select. It computes one of four operations on two 8-bit operands every clock cycle and presents the result and status flags one cycle later. It is a leaf datapath block with no handshake; upstream logic holds or changes operands freely, and downstream logic samples the outputs on any clock edge.

## Interface

Parameters:
- None. Widths are fixed: operands and result 8 bits, opcode 2 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- opcode  input  2  operation select, encoded as the shared enum op_code_e: ADD=2'b00, SUB=2'b01, INV=2'b10, ORR=2'b11.
- Y  output  8  registered result.
- carry  output  1  registered carry/borrow flag.
- zero  output  1  registered flag; 1 when Y == 8'h00.

## Operation

- Combinational next-result, selected by opcode:
  - ADD: Y_next = (A + B) mod 256; carry_next = bit 8 of the 9-bit sum.
  - SUB: Y_next = (A - B) mod 256, two's-complement wrap; carry_next = 1 if A < B (borrow), else 0.
  - INV: Y_next = ~A. B is ignored. carry_next = 0.
  - ORR: Y_next = A | B; carry_next = 0.
- zero_next = (Y_next == 8'h00), evaluated after the operation.
- All four opcode values are defined, so no illegal or default-trap state exists. The default branch of the case statement maps to ADD for X-safety.
- The block has no internal state beyond the output registers and no FSM.
- Operands are treated as unsigned. Signed overflow is not flagged.

## Timing

- While rst_n = 0 (asserted asynchronously, without waiting for a clock): Y = 8'h00, carry = 0, zero = 1. These values are consistent with Y = 0.
- Reset release is synchronized by the first rising clk edge after rst_n goes high. The first computed result appears on that edge.
- Latency is exactly 1 cycle. A, B and opcode sampled at rising edge N appear on Y, carry and zero immediately after edge N, and hold until edge N+1.
- Throughput is one operation per cycle. Back-to-back opcode or operand changes each produce their own result on consecutive edges.
- Reset asserted mid-stream forces the reset values immediately. The in-flight result is discarded.
- If inputs change between clock edges, outputs do not change; only values present at the edge matter.
- Wrap-around cases:
  - ADD 8'hFF + 8'h01 gives Y = 00, carry = 1, zero = 1.
  - SUB 8'h00 - 8'h01 gives Y = FF, carry = 1, zero = 0.
  - SUB with A == B gives Y = 00, carry = 0, zero = 1.

## Test plan

- Reset: hold rst_n = 0 with A = 8'h0F, B = 8'hF0 and clocks running -> Y = 00, carry = 0, zero = 1. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Opcode sweep with A = 8'h0F, B = 8'hF0, stepping ADD, SUB, INV, ORR on successive cycles. Each result appears one cycle after its opcode:
  - ADD -> Y = FF, carry = 0.
  - SUB -> Y = 1F, carry = 1.
  - INV -> Y = F0, carry = 0.
  - ORR -> Y = FF, carry = 0.
  - zero = 0 throughout.
- ADD overflow: A = FF, B = 01 -> Y = 00, carry = 1, zero = 1. Then A = 80, B = 80 -> Y = 00, carry = 1, zero = 1.
- SUB edges:
  - A = 00, B = 01 -> Y = FF, carry = 1.
  - A = 55, B = 55 -> Y = 00, carry = 0, zero = 1.
  - A = F0, B = 0F -> Y = E1, carry = 0.
- INV/ORR:
  - INV with A = FF, B = 12 -> Y = 00, zero = 1 (B ignored).
  - ORR with A = 00, B = 00 -> Y = 00, zero = 1.
  - ORR with A = A5, B = 5A -> Y = FF.
- Latency/hold: change inputs between edges only -> outputs unchanged until the next rising edge. Random A/B/opcode for 1000 cycles, compared against a reference model with a 1-cycle delay.
